// File: rtl/q_sys_loader_pkg.sv
// -----------------------------------------------------------------------------
// q_sys_loader_pkg -- shared types and constants for the RAM loader. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package q_sys_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned c_LANES  = 4;
  localparam int unsigned c_LANE_W = 2;
  localparam int unsigned c_DATA_W = 8 * c_LANES;
  localparam int unsigned c_ADDR_W = 9;
  localparam int unsigned c_WC_W   = c_ADDR_W + 1;

endpackage : q_sys_loader_pkg

`default_nettype wire

// File: rtl/q_sys_byte_packer.sv
// -----------------------------------------------------------------------------
// q_sys_byte_packer -- little-endian byte-to-word lane register with byteenables. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module q_sys_byte_packer
  import q_sys_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic                i_load,
  input  logic                i_clear,
  input  logic [7:0]          i_byte,
  output logic [c_DATA_W-1:0] o_data,
  output logic [c_LANES-1:0]  o_be,
  output logic [c_LANE_W-1:0] o_lane
);

  logic [c_DATA_W-1:0] r_data;
  logic [c_LANES-1:0]  r_be;
  logic [c_LANE_W-1:0] r_lane;

  // A start always lands in lane 0 and throws away whatever was pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_be   <= '0;
      r_lane <= '0;
    end else if (i_start) begin
      r_data <= {{(c_DATA_W-8){1'b0}}, i_byte};
      r_be   <= c_LANES'(1);
      r_lane <= c_LANE_W'(1);
    end else if (i_clear) begin
      r_data <= '0;
      r_be   <= '0;
      r_lane <= '0;
    end else if (i_load) begin
      r_data[{r_lane, 3'b000} +: 8] <= i_byte;
      r_be[r_lane]                  <= 1'b1;
      r_lane                        <= r_lane + c_LANE_W'(1);
    end
  end

  assign o_data = r_data;
  assign o_be   = r_be;
  assign o_lane = r_lane;

endmodule : q_sys_byte_packer

`default_nettype wire

// File: rtl/q_sys_ram_loader.sv
// -----------------------------------------------------------------------------
// q_sys_ram_loader -- loads an Avalon-ST byte packet into a 32-bit word RAM. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module q_sys_ram_loader
  import q_sys_loader_pkg::*;
#(
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 512
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          snk_data,
  input  logic                snk_valid,
  input  logic                snk_startofpacket,
  input  logic                snk_endofpacket,
  output logic                snk_ready,
  output logic [c_ADDR_W-1:0] ram_address,
  output logic [c_LANES-1:0]  ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [c_DATA_W-1:0] ram_writedata,
  output logic                ram_clken,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [c_WC_W-1:0]   word_count
);

  localparam int c_END   = BASE_ADDR + DEPTH;
  localparam int c_LIMIT = (c_END > (1 << c_ADDR_W)) ? (1 << c_ADDR_W) : c_END;
  localparam logic [c_ADDR_W:0]   c_LIMIT_A = c_LIMIT[c_ADDR_W:0];
  localparam logic [c_ADDR_W:0]   c_BASE_A  = BASE_ADDR[c_ADDR_W:0];
  localparam logic [c_LANE_W-1:0] c_LAST    = c_LANE_W'(c_LANES - 1);

  state_t r_state, w_next;

  logic                r_run;
  logic                r_eop;
  logic                r_ovf;
  logic [c_ADDR_W:0]   r_addr;
  logic [c_WC_W-1:0]   r_wc;

  logic                w_accept;
  logic                w_start;
  logic                w_load;
  logic                w_clear;
  logic                w_addr_bad;
  logic                w_wr;
  logic [c_DATA_W-1:0] w_pk_data;
  logic [c_LANES-1:0]  w_pk_be;
  logic [c_LANE_W-1:0] w_pk_lane;

  q_sys_byte_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (w_start),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_byte  (snk_data),
    .o_data  (w_pk_data),
    .o_be    (w_pk_be),
    .o_lane  (w_pk_lane)
  );

  // r_run keeps ready/clken low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  assign w_accept = snk_valid & snk_ready;

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_load  = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && snk_startofpacket) begin
          w_start = 1'b1;
          w_next  = snk_endofpacket ? ST_WRITE : ST_PACK;
        end
      end
      ST_PACK: begin
        if (w_accept) begin
          if (snk_startofpacket) begin
            w_start = 1'b1;
            w_next  = snk_endofpacket ? ST_WRITE : ST_PACK;
          end else begin
            w_load = 1'b1;
            if ((w_pk_lane == c_LAST) || snk_endofpacket) begin
              w_next = ST_WRITE;
            end
          end
        end
      end
      ST_WRITE: begin
        w_clear = 1'b1;
        w_next  = r_eop ? ST_DONE : ST_PACK;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_eop <= 1'b0;
    end else if (w_start || w_load) begin
      r_eop <= snk_endofpacket;
    end
  end

  // The address stops advancing once out of range, so the limit is sticky.
  assign w_addr_bad = (r_addr >= c_LIMIT_A);
  assign w_wr       = (r_state == ST_WRITE) && !w_addr_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= c_BASE_A;
      r_wc   <= '0;
      r_ovf  <= 1'b0;
    end else if (w_start) begin
      r_addr <= c_BASE_A;
      r_wc   <= '0;
      r_ovf  <= 1'b0;
    end else if (r_state == ST_WRITE) begin
      if (w_addr_bad) begin
        r_ovf <= 1'b1;
      end else begin
        r_addr <= r_addr + 1'b1;
        r_wc   <= r_wc + 1'b1;
      end
    end
  end

  assign snk_ready      = r_run && ((r_state == ST_IDLE) || (r_state == ST_PACK));
  assign ram_write      = w_wr;
  assign ram_chipselect = w_wr;
  assign ram_writedata  = w_wr ? w_pk_data : '0;
  assign ram_byteenable = w_wr ? w_pk_be : '0;
  assign ram_address    = r_addr[c_ADDR_W-1:0];
  assign ram_clken      = r_run;
  assign busy           = (r_state != ST_IDLE);
  assign done           = (r_state == ST_DONE);
  assign overflow       = r_ovf;
  assign word_count     = r_wc;

endmodule : q_sys_ram_loader

`default_nettype wire
